fft_detect_sequencer: RTL

//  Frame-level controller for the FFT -> freqdetect chain. On a frame start it runs the shared FFT

---
 rtl/fft_detect_sequencer.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/fft_detect_sequencer.sv
// Frame controller for the shared FFT -> freqdetect chain: per-channel sequencing,
// peak-bin collection, atomic frame publish and magnitude RAM read-port arbitration.
//
// Ports:
//   clk, reset (async, active-low)      clock and reset
//   start                               frame request pulse (honoured only in IDLE)
//   fft_start, fft_ch, fftdone          FFT launch pulse, routed channel, completion
//   det_go, detectdone, det_maxbin      freqdetect enable level, completion, peak bin
//   det_ramaddr, host_req, host_addr    RAM read requesters
//   host_gnt, ram_addr                  host grant and muxed RAM read address
//   bins_out, frame_valid               published peak bins (ch0 in LSBs) and update pulse
//   busy, timeout_err                   not-idle flag and sticky watchdog-abort flag
//
// Configuration macro FDS_HOST_ARB_EN: when defined the host may use the RAM read port
// outside DETECT; when undefined the port belongs to freqdetect and the host is never granted.
module fft_detect_sequencer #(
    parameter int NCH     = 4,
    parameter int ADDR_W  = 11,
    parameter int TMO_CYC = 8191,
    localparam int CH_W   = $clog2(NCH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  fft_start,
    output logic [CH_W-1:0]       fft_ch,
    input  logic                  fftdone,
    output logic                  det_go,
    input  logic                  detectdone,
    input  logic [ADDR_W-1:0]     det_maxbin,
    input  logic [ADDR_W-1:0]     det_ramaddr,
    input  logic                  host_req,
    input  logic [ADDR_W-1:0]     host_addr,
    output logic                  host_gnt,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [NCH*ADDR_W-1:0] bins_out,
    output logic                  frame_valid,
    output logic                  busy,
    output logic                  timeout_err
);

    localparam int WD_W = $clog2(TMO_CYC + 1);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        FFT_WAIT,
        DETECT,
        NEXT,
        PUBLISH
    } state_t;

    state_t            state, state_n;
    logic [CH_W-1:0]   ch, ch_n;
    logic [WD_W-1:0]   wdog, wdog_n;
    logic [ADDR_W-1:0] shadow [NCH];
    logic              expired;
    logic              cap;
    logic              pub;
    logic              tmo_set;
    logic              tmo_clr;

    // Expiry is the TMO_CYC-th cycle spent in a watched phase; a done event
    // in that same cycle takes priority in the next-state logic below.
    assign expired = (wdog == WD_W'(TMO_CYC - 1));

    always_comb begin
        state_n = state;
        ch_n    = ch;
        wdog_n  = wdog;
        cap     = 1'b0;
        pub     = 1'b0;
        tmo_set = 1'b0;
        tmo_clr = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n = LAUNCH;
                    ch_n    = '0;
                    tmo_clr = 1'b1;
                end
            end
            LAUNCH: begin
                wdog_n  = '0;
                state_n = FFT_WAIT;
            end
            FFT_WAIT: begin
                if (fftdone) begin
                    wdog_n  = '0;
                    state_n = DETECT;
                end else if (expired) begin
                    tmo_set = 1'b1;
                    ch_n    = '0;
                    state_n = IDLE;
                end else begin
                    wdog_n = wdog + WD_W'(1);
                end
            end
            DETECT: begin
                if (detectdone) begin
                    cap     = 1'b1;
                    state_n = NEXT;
                end else if (expired) begin
                    tmo_set = 1'b1;
                    ch_n    = '0;
                    state_n = IDLE;
                end else begin
                    wdog_n = wdog + WD_W'(1);
                end
            end
            NEXT: begin
                if (ch == CH_W'(NCH - 1)) begin
                    state_n = PUBLISH;
                end else begin
                    ch_n    = ch + CH_W'(1);
                    state_n = LAUNCH;
                end
            end
            PUBLISH: begin
                pub     = 1'b1;
                ch_n    = '0;
                state_n = IDLE;
            end
            default: begin
                ch_n    = '0;
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            ch          <= '0;
            wdog        <= '0;
            bins_out    <= '0;
            frame_valid <= 1'b0;
            timeout_err <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            state       <= state_n;
            ch          <= ch_n;
            wdog        <= wdog_n;
            frame_valid <= pub;
            if (cap) begin
                shadow[ch] <= det_maxbin;
            end
            // frame_valid and bins_out change on the same edge so the
            // pulse always qualifies the freshly published frame.
            if (pub) begin
                for (int i = 0; i < NCH; i++) begin
                    bins_out[i*ADDR_W +: ADDR_W] <= shadow[i];
                end
            end
            if (tmo_clr) begin
                timeout_err <= 1'b0;
            end else if (tmo_set) begin
                timeout_err <= 1'b1;
            end
        end
    end

    assign fft_start = (state == LAUNCH);
    assign fft_ch    = ch;
    assign det_go    = (state == DETECT);
    assign busy      = (state != IDLE);

`ifdef FDS_HOST_ARB_EN
    // freqdetect has absolute priority during DETECT; the host is dropped
    // without notice and must watch host_gnt every cycle.
    assign host_gnt = host_req & ~det_go;
    assign ram_addr = det_go ? det_ramaddr : host_addr;
`else
    logic unused_host;
    assign unused_host = ^{host_req, host_addr};
    assign host_gnt    = 1'b0;
    assign ram_addr    = det_ramaddr;
`endif

endmodule
